// File: rtl/pipe_pkg.sv
// Shared types and constants for the EXE->MEM pipeline register slice.
package pipe_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int REG_W_DEF    = 4;
    localparam int MEMCTL_W_DEF = 2;

    localparam int MEMCTL_RD_BIT = 0;
    localparam int MEMCTL_WR_BIT = 1;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } skid_state_t;

    typedef struct packed {
        logic [MEMCTL_W_DEF-1:0] memctl;
        logic                    wb;
        logic [DATA_W_DEF-1:0]   alu;
        logic [DATA_W_DEF-1:0]   wdata;
        logic [REG_W_DEF-1:0]    wreg;
    } exe_mem_pkt_t;

    function automatic int pkt_width(input int data_w, input int reg_w, input int memctl_w);
        return memctl_w + 1 + 2 * data_w + reg_w;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register of the skid pair: synchronous clear beats load enable.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/exe_mem_skid.sv
// EXE->MEM pipeline register with a two-entry skid buffer, flush and forwarding tap.
// in_ready and out_valid depend only on the state register, so no ready path crosses the stage.
module exe_mem_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int REG_W    = 4,
    parameter int MEMCTL_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MEMCTL_W-1:0] controlmem_in,
    input  logic                controlwb_in,
    input  logic [DATA_W-1:0]   alu_in,
    input  logic [DATA_W-1:0]   wdata_in,
    input  logic [REG_W-1:0]    wreg_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                memread_out,
    output logic                memwrite_out,
    output logic                controlwb_out,
    output logic [DATA_W-1:0]   alu_out,
    output logic [DATA_W-1:0]   wdata_out,
    output logic [REG_W-1:0]    wreg_out,
    output logic                fwd_valid,
    output logic [REG_W-1:0]    fwd_reg,
    output logic [DATA_W-1:0]   fwd_data
);

    localparam int PKT_W = pkt_width(DATA_W, REG_W, MEMCTL_W);

    typedef struct packed {
        logic [MEMCTL_W-1:0] memctl;
        logic                wb;
        logic [DATA_W-1:0]   alu;
        logic [DATA_W-1:0]   wdata;
        logic [REG_W-1:0]    wreg;
    } pkt_t;

    skid_state_t state;
    skid_state_t state_next;

    pkt_t in_pkt;
    pkt_t head_d;
    pkt_t head_pkt;
    pkt_t skid_pkt;

    logic accept;
    logic fire;
    logic load_head;
    logic load_skid;
    logic head_from_skid;

    assign in_pkt = '{memctl: controlmem_in, wb: controlwb_in, alu: alu_in,
                      wdata: wdata_in, wreg: wreg_in};

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign fire      = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Flush wins over everything except reset; a same-cycle accept is simply never loaded.
    always_comb begin
        state_next     = state;
        load_head      = 1'b0;
        load_skid      = 1'b0;
        head_from_skid = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_next = ONE;
                        load_head  = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && fire) begin
                        load_head = 1'b1;
                    end else if (accept) begin
                        state_next = TWO;
                        load_skid  = 1'b1;
                    end else if (fire) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (fire) begin
                        state_next     = ONE;
                        load_head      = 1'b1;
                        head_from_skid = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    assign head_d = head_from_skid ? skid_pkt : in_pkt;

    pipe_slot #(.W(PKT_W)) u_head (
        .clk  (clk),
        .rst  (rst),
        .load (load_head),
        .d    (head_d),
        .q    (head_pkt)
    );

    pipe_slot #(.W(PKT_W)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (load_skid),
        .d    (in_pkt),
        .q    (skid_pkt)
    );

    // Controls are gated so an empty stage always looks like a bubble downstream.
    assign memread_out   = out_valid & head_pkt.memctl[MEMCTL_RD_BIT];
    assign memwrite_out  = out_valid & head_pkt.memctl[MEMCTL_WR_BIT];
    assign controlwb_out = out_valid & head_pkt.wb;
    assign alu_out       = head_pkt.alu;
    assign wdata_out     = head_pkt.wdata;
    assign wreg_out      = head_pkt.wreg;

    assign fwd_valid = out_valid & controlwb_out & ~memread_out;
    assign fwd_reg   = head_pkt.wreg;
    assign fwd_data  = head_pkt.alu;

endmodule

// File: tb/tb_exe_mem_skid.sv
// Self-checking bench: directed steps plus random traffic against a two-deep FIFO model.
module tb_exe_mem_skid;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready, controlwb_in;
    logic [1:0]  controlmem_in;
    logic [15:0] alu_in, wdata_in;
    logic [3:0]  wreg_in;
    logic        in_ready, out_valid, memread_out, memwrite_out, controlwb_out, fwd_valid;
    logic [15:0] alu_out, wdata_out, fwd_data;
    logic [3:0]  wreg_out, fwd_reg;

    logic        w_flush, w_in_valid, w_out_ready, w_controlwb_in;
    logic [1:0]  w_controlmem_in;
    logic [31:0] w_alu_in, w_wdata_in;
    logic [4:0]  w_wreg_in;
    logic        w_in_ready, w_out_valid, w_memread_out, w_memwrite_out, w_controlwb_out, w_fwd_valid;
    logic [31:0] w_alu_out, w_wdata_out, w_fwd_data;
    logic [4:0]  w_wreg_out, w_fwd_reg;

    exe_mem_skid dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .controlmem_in(controlmem_in), .controlwb_in(controlwb_in), .alu_in(alu_in),
        .wdata_in(wdata_in), .wreg_in(wreg_in), .out_valid(out_valid), .out_ready(out_ready),
        .memread_out(memread_out), .memwrite_out(memwrite_out), .controlwb_out(controlwb_out),
        .alu_out(alu_out), .wdata_out(wdata_out), .wreg_out(wreg_out),
        .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
    );

    exe_mem_skid #(.DATA_W(32), .REG_W(5), .MEMCTL_W(2)) dut_wide (
        .clk(clk), .rst(rst), .flush(w_flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .controlmem_in(w_controlmem_in), .controlwb_in(w_controlwb_in), .alu_in(w_alu_in),
        .wdata_in(w_wdata_in), .wreg_in(w_wreg_in), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .memread_out(w_memread_out), .memwrite_out(w_memwrite_out), .controlwb_out(w_controlwb_out),
        .alu_out(w_alu_out), .wdata_out(w_wdata_out), .wreg_out(w_wreg_out),
        .fwd_valid(w_fwd_valid), .fwd_reg(w_fwd_reg), .fwd_data(w_fwd_data)
    );

    typedef struct {
        logic [1:0]  memctl;
        logic        wb;
        logic [15:0] alu;
        logic [15:0] wdata;
        logic [3:0]  wreg;
    } entry_t;

    entry_t model_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        entry_t h;
        chk("in_ready", {31'd0, in_ready}, {31'd0, model_q.size() < 2});
        chk("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() != 0});
        if (model_q.size() == 0) begin
            chk("memread_bubble", {31'd0, memread_out}, 32'd0);
            chk("memwrite_bubble", {31'd0, memwrite_out}, 32'd0);
            chk("wb_bubble", {31'd0, controlwb_out}, 32'd0);
            chk("fwd_valid_bubble", {31'd0, fwd_valid}, 32'd0);
        end else begin
            h = model_q[0];
            chk("memread", {31'd0, memread_out}, {31'd0, h.memctl[0]});
            chk("memwrite", {31'd0, memwrite_out}, {31'd0, h.memctl[1]});
            chk("controlwb", {31'd0, controlwb_out}, {31'd0, h.wb});
            chk("alu_out", {16'd0, alu_out}, {16'd0, h.alu});
            chk("wdata_out", {16'd0, wdata_out}, {16'd0, h.wdata});
            chk("wreg_out", {28'd0, wreg_out}, {28'd0, h.wreg});
            chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, h.wb & ~h.memctl[0]});
            chk("fwd_reg", {28'd0, fwd_reg}, {28'd0, h.wreg});
            chk("fwd_data", {16'd0, fwd_data}, {16'd0, h.alu});
        end
    endtask

    // Stage behaves as a two-deep FIFO: MEM consumes the oldest, EXE appends while space remains.
    task automatic modelStep();
        entry_t e;
        bit     pop;
        bit     push;
        if (rst || flush) begin
            model_q.delete();
        end else begin
            pop  = (model_q.size() > 0) && out_ready;
            push = in_valid && (model_q.size() < 2);
            if (pop) void'(model_q.pop_front());
            if (push) begin
                e.memctl = controlmem_in;
                e.wb     = controlwb_in;
                e.alu    = alu_in;
                e.wdata  = wdata_in;
                e.wreg   = wreg_in;
                model_q.push_back(e);
            end
        end
    endtask

    task automatic tick();
        checkOutput();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] mc, input logic wb,
                                 input logic [15:0] alu, input logic [15:0] wd,
                                 input logic [3:0] wr, input logic rdy, input logic fl);
        in_valid      = v;
        controlmem_in = mc;
        controlwb_in  = wb;
        alu_in        = alu;
        wdata_in      = wd;
        wreg_in       = wr;
        out_ready     = rdy;
        flush         = fl;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b1, 2'b11, 1'b1, 16'hAAAA, 16'h5555, 4'hF, 1'b0, 1'b0);
        w_flush = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b1; w_controlwb_in = 1'b0;
        w_controlmem_in = 2'b00; w_alu_in = '0; w_wdata_in = '0; w_wreg_in = '0;
        @(posedge clk);
        #1;
        model_q.delete();

        $display("[TB] reset");
        tick();
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 2'b00, 1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
        chk("reset_alu_zero", {16'd0, alu_out}, 32'd0);
        chk("reset_wdata_zero", {16'd0, wdata_out}, 32'd0);
        chk("reset_wreg_zero", {28'd0, wreg_out}, 32'd0);
        tick();

        $display("[TB] streaming");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 2'b00, 1'b1, 16'(i), 16'(i * 3), 4'(i), 1'b1, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 2'b00, 1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
        tick();
        tick();

        $display("[TB] stall and skid");
        applyStimulus(1'b1, 2'b10, 1'b0, 16'h1111, 16'hA1A1, 4'h1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 2'b01, 1'b1, 16'h2222, 16'hB2B2, 4'h2, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 2'b00, 1'b1, 16'h3333, 16'hC3C3, 4'h3, 1'b0, 1'b0);
        tick();
        chk("skid_full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("skid_head_is_A", {16'd0, alu_out}, 32'h1111);
        tick();
        out_ready = 1'b1;
        tick();
        chk("skid_head_is_B", {16'd0, alu_out}, 32'h2222);
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
        chk("skid_head_is_C", {16'd0, alu_out}, 32'h3333);
        tick();
        tick();

        $display("[TB] flush");
        applyStimulus(1'b1, 2'b10, 1'b0, 16'h4444, 16'h0404, 4'h4, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 2'b10, 1'b0, 16'h5555, 16'h0505, 4'h5, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 2'b10, 1'b1, 16'h5A5A, 16'h0606, 4'h6, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_memwrite", {31'd0, memwrite_out}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        tick();

        $display("[TB] forwarding");
        applyStimulus(1'b1, 2'b01, 1'b1, 16'h0100, 16'h0000, 4'h3, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 2'b00, 1'b1, 16'hBEEF, 16'h0000, 4'h5, 1'b1, 1'b0);
        chk("fwd_load_blocked", {31'd0, fwd_valid}, 32'd0);
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
        chk("fwd_alu_valid", {31'd0, fwd_valid}, 32'd1);
        chk("fwd_alu_reg", {28'd0, fwd_reg}, 32'd5);
        chk("fwd_alu_data", {16'd0, fwd_data}, 32'hBEEF);
        out_ready = 1'b1;
        tick();
        tick();

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(63) == 0);
            applyStimulus(1'($urandom), 2'($urandom), 1'($urandom), 16'($urandom),
                          16'($urandom), 4'($urandom), 1'($urandom_range(3) != 0),
                          ($urandom_range(15) == 0));
            tick();
        end
        rst = 1'b0;
        applyStimulus(1'b0, 2'b00, 1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
        tick();
        tick();

        $display("[TB] wide instance");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("wide_reset_valid", {31'd0, w_out_valid}, 32'd0);
        chk("wide_reset_alu", w_alu_out, 32'd0);
        w_in_valid = 1'b1; w_controlmem_in = 2'b00; w_controlwb_in = 1'b1;
        w_alu_in = 32'hDEADBEEF; w_wdata_in = 32'h01234567; w_wreg_in = 5'h1F;
        tick();
        chk("wide_valid_1", {31'd0, w_out_valid}, 32'd1);
        chk("wide_alu_1", w_alu_out, 32'hDEADBEEF);
        chk("wide_wdata_1", w_wdata_out, 32'h01234567);
        chk("wide_wreg_1", {27'd0, w_wreg_out}, 32'h1F);
        chk("wide_fwd_1", w_fwd_data, 32'hDEADBEEF);
        w_alu_in = 32'hCAFEF00D; w_wreg_in = 5'h11;
        tick();
        w_in_valid = 1'b0;
        chk("wide_alu_2", w_alu_out, 32'hCAFEF00D);
        chk("wide_wreg_2", {27'd0, w_wreg_out}, 32'h11);
        chk("wide_in_ready", {31'd0, w_in_ready}, 32'd1);
        tick();
        chk("wide_drained", {31'd0, w_out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exe_mem_skid.md
# exe_mem_skid

Parametrised EXE→MEM pipeline register with a valid/ready handshake, a two-entry skid buffer, a synchronous flush and a registered forwarding tap. It sits between the ALU stage and the data-memory stage. It lets a slow memory access (SRAM/UART busy) stall the MEM side without a combinational ready path back into EXE. When the register holds no valid entry, all control outputs are forced to a bubble (no read, no write, no writeback).

## Interface
- `DATA_W`, 16: width of ALU result and store data.
- `REG_W`, 4: width of the destination register index.
- `MEMCTL_W`, 2: width of the memory control field. Bit 0 is read, bit 1 is write. Must be ≥ 2.

- `clk`  in  1  clock. All state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  squash all held entries (branch mispredict / exception).
- `in_valid`  in  1  EXE presents a valid instruction.
- `in_ready`  out  1  stage can accept. Registered: a function of state only.
- `controlmem_in`  in  MEMCTL_W  memory control.
- `controlwb_in`  in  1  register writeback enable.
- `alu_in`  in  DATA_W  ALU result / address.
- `wdata_in`  in  DATA_W  store data.
- `wreg_in`  in  REG_W  destination register.
- `out_valid`  out  1  MEM-side entry valid.
- `out_ready`  in  1  MEM stage consumes the entry this cycle.
- `memread_out`, `memwrite_out`, `controlwb_out`  out  1 each  gated with `out_valid`.
- `alu_out`, `wdata_out`  out  DATA_W  payload of the head entry.
- `wreg_out`  out  REG_W  payload of the head entry.
- `fwd_valid`  out  1  head entry can forward its value: `out_valid & controlwb_out & ~memread_out`.
- `fwd_reg`  out  REG_W  equals `wreg_out`.
- `fwd_data`  out  DATA_W  equals `alu_out`.

## Operation
- Holds two slots: `head`, which drives the outputs, and `skid`. The state is EMPTY, ONE or TWO.
- accept = `in_valid & in_ready`. fire = `out_valid & out_ready`.
- `in_ready` = (state ≠ TWO). `out_valid` = (state ≠ EMPTY).
- Transitions when flush = 0:
  - EMPTY: accept → ONE, head ← in.
  - ONE: accept & fire → ONE, head ← in. accept & ~fire → TWO, skid ← in. ~accept & fire → EMPTY.
  - TWO: fire → ONE, head ← skid. Otherwise hold.
- flush = 1 → EMPTY unconditionally. Any accept in the same cycle is discarded. Payload registers may keep stale data, but the gated controls read as 0.
- rst overrides flush. Reset values:
  - state EMPTY, so `in_ready` = 1 and `out_valid` = 0.
  - All control outputs 0, `fwd_valid` = 0.
  - Payload outputs 0 (payload slots are cleared on reset).
- Entry order is strict FIFO. No entry is duplicated or dropped except on flush.
- Reset mid-operation discards both entries. The cycle after reset is EMPTY.

## Timing
- Latency: an instruction accepted at edge N is visible on the outputs after edge N, with `out_valid` = 1 in cycle N+1.
- Throughput: 1 instruction per cycle while `out_ready` = 1.
- `in_ready` drops on the edge after the skid slot fills. It has no combinational path from `out_ready` or `flush`.
- With `out_ready` held low, the stage absorbs exactly 2 instructions, then `in_ready` = 0.
- Forwarding outputs come purely from the head registers. They are valid in the same cycle as `out_valid`.

## Structure
- Shared package `pipe_pkg` holds:
  - the state enum `skid_state_t` {EMPTY, ONE, TWO};
  - `MEMCTL_RD_BIT` = 0 and `MEMCTL_WR_BIT` = 1;
  - the payload struct `exe_mem_pkt_t` (memctl, wb, alu, wdata, wreg), parametrised via the package defaults.
- One sub-module, `pipe_slot`: a single payload register with synchronous clear and load enable. It is instantiated twice (head, skid).

## Test plan
- Reset: assert `rst` for 2 cycles with `in_valid` = 1. Required: `out_valid` = 0, all controls 0, `in_ready` = 1, `alu_out` = 0x0000.
- Streaming: 4 back-to-back inputs with `out_ready` = 1, `alu_in` = 0x0001..0x0004. Required: outputs 0x0001..0x0004 on consecutive cycles, each one cycle after its input. `in_ready` stays 1.
- Stall/skid: `out_ready` = 0 and inputs A = 0x1111, B = 0x2222, C = 0x3333 offered. Required: A and B accepted, `in_ready` = 0 from the cycle after B, C held upstream. After `out_ready` = 1, the output order is A, B, C with no loss.
- Flush: state TWO, then pulse `flush` with `in_valid` = 1. Required: next cycle `out_valid` = 0, `memwrite_out` = 0, `in_ready` = 1, and the flushed-cycle input never appears.
- Forwarding: load entry (memctl = 01, wb = 1, wreg = 3). Required: `fwd_valid` = 0. Then an ALU entry (memctl = 00, wb = 1, wreg = 5, alu = 0xBEEF). Required: `fwd_valid` = 1, `fwd_reg` = 5, `fwd_data` = 0xBEEF.
- Width: instantiate `DATA_W` = 32, `REG_W` = 5 and rerun the streaming test with 0xDEADBEEF. Required: the value is passed intact.
